rf_writeback_unit: RTL and testbench
====================================

Name: rf_writeback_unit

Overview:
- Producer side of the register-file write port: collects results from the ALU path and the load/memory path and issues at most one write per cycle on `we_RF`/`rd`/`WD3`.
- The register file samples these outputs on the falling clock edge, so every output here is registered on the rising edge.
- Keeps a per-register pending (scoreboard) vector so the issue logic can stall reads of registers whose writes have not yet committed.

Parameters:
- `MEM_FIFO_DEPTH`, 4: entries in the memory-result buffer; power of two, minimum 2.
- `DATA_W`, 32: result data width.
- `REG_AW`, 4: register address width.
- `NUM_REGS`, 15: architectural registers held in the bank (indices 0..14).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, active-low, asynchronous.
- `alu_valid`  in  1  ALU result offered.
- `alu_rd`  in  4  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid` & `alu_ready`.
- `mem_valid`  in  1  load result offered.
- `mem_rd`  in  4  load destination register.
- `mem_data`  in  32  load result.
- `mem_ready`  out  1  load result accepted when `mem_valid` & `mem_ready`.
- `mark_valid`  in  1  issue stage reserves a destination register.
- `mark_rd`  in  4  register being reserved.
- `we_RF`  out  1  register-file write enable.
- `rd`  out  4  register-file write address.
- `WD3`  out  32  register-file write data.
- `pending`  out  15  bit i set = a write to register i is outstanding.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - `we_RF`=0, `rd`=0, `WD3`=0, `pending`=0.
  - FIFO emptied (count=0, pointers=0).
  - Reset in mid-operation discards all buffered and in-flight results; no write is issued in the cycle after reset is released.
- Selection, evaluated each cycle before the rising edge:
  - (a) FIFO full (count==`MEM_FIFO_DEPTH`): commit the FIFO head.
  - (b) else if `alu_valid`: commit the ALU result.
  - (c) else if FIFO non-empty: commit the FIFO head.
  - (d) else: no commit.
- Ready signals:
  - `alu_ready` = (count != `MEM_FIFO_DEPTH`).
  - `mem_ready` = (count != `MEM_FIFO_DEPTH`) | (head dequeued this cycle). Enqueue and dequeue in the same cycle at full leaves count unchanged.
- Output register on a commit:
  - Loaded at the rising edge: `we_RF`=1, `rd`=selected rd, `WD3`=selected data.
  - With no commit, `we_RF`=0; `rd` and `WD3` hold their previous values.
- Latency:
  - ALU accepted at edge N → `we_RF` high during cycle N+1; the register file writes at the falling edge in N+1.
  - Load accepted at edge N → earliest `we_RF` in cycle N+2. There is no FIFO bypass.
- Ordering:
  - Loads commit in FIFO order.
  - ALU and load results to the same rd may commit in either order. The issue stage guarantees this through `pending`; the unit does not reorder.
- rd==15 (PC, not in the bank):
  - Accepted and handshaked normally, but committed with `we_RF`=0.
  - Its slot is consumed; `pending` is unaffected.
- `pending`:
  - Set bit `mark_rd` on `mark_valid` (ignored when `mark_rd`==15).
  - Clear bit `rd` on a commit with `we_RF`=1.
  - Simultaneous set and clear of the same bit: set wins.
  - Clearing an already-clear bit is legal and silent.
- FIFO:
  - Circular buffer; pointers wrap modulo `MEM_FIFO_DEPTH`.
  - Count is `$clog2(MEM_FIFO_DEPTH)+1` bits wide and never exceeds depth.
  - Overflow is impossible by construction. An assertion flags an enqueue while full without a dequeue.
- Data widths: no arithmetic on data; `rd`/`data` are passed through unmodified.

Decomposition:
- Package `wb_pkg`:
  - Constants: `NUM_REGS`=15, `PC_IDX`=4'd15.
  - `typedef struct packed {logic [3:0] rd; logic [31:0] data;} wb_req_t`.
  - Enum `wb_src_e` {`SRC_NONE`, `SRC_ALU`, `SRC_MEM`} for the selection.
- Sub-module `wb_fifo`:
  - Parameterised on depth and carrying `wb_req_t`.
  - Ports: push/pop, full/empty, count, head.
  - Same asynchronous active-low reset.

Test Plan:
- ALU only: `alu_valid` with rd=3, data=0xDEADBEEF for one cycle → next cycle `we_RF`=1, `rd`=3, `WD3`=0xDEADBEEF; the cycle after, `we_RF`=0; bank[3]=0xDEADBEEF.
- Load latency: `mem_valid` with rd=5, data=0x12345678, ALU idle → `we_RF`=1 with `rd`=5 exactly two cycles after the accept edge.
- Priority and full:
  - Stimulus: hold `alu_valid` (rd=1) continuously and push 4 loads (rd=7..10).
  - Loads 7..10 are pushed while `alu_ready`=1; the FIFO then reaches 4 entries.
  - Response: `alu_ready` drops; loads 7..10 commit in order; ALU resumes only after the drain starts.
- Full with simultaneous push/pop: FIFO full, head committing, `mem_valid` rd=2 → `mem_ready`=1 and count stays 4.
- Scoreboard:
  - `mark_valid` rd=6 → `pending[6]`=1; a commit to rd=6 clears it.
  - `mark` rd=6 in the same cycle as a commit to rd=6 → `pending[6]` stays 1.
- PC and reset:
  - ALU rd=15 → handshake completes, `we_RF` stays 0, `pending` unchanged.
  - Assert `rst`=0 with 3 loads buffered → all outputs 0 immediately; after release, no writes occur.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_AW = 4;
  localparam int unsigned NUM_REGS  = 15;
  localparam logic [WB_REG_AW-1:0] PC_IDX = 4'd15;

  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;

  // PC (index 15) is not held in the bank and never gets a write enable.
  function automatic logic is_banked(input logic [WB_REG_AW-1:0] r);
    return r != PC_IDX;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load results; pointers wrap modulo DEPTH.
module wb_fifo
  import wb_pkg::wb_req_t;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_req_t                  din,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count,
  output wb_req_t                  head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];

  // Storage carries no reset: validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_chk : assert property (@(posedge clk) disable iff (!rst) !(push && full_c && !pop))
    else $error("wb_fifo: enqueue while full without dequeue");

endmodule

// File: rtl/rf_writeback_unit.sv
// Arbitrates ALU and load results onto the single register-file write port
// and tracks outstanding writes per register.
module rf_writeback_unit
  import wb_pkg::wb_req_t;
  import wb_pkg::wb_src_e;
  import wb_pkg::SRC_NONE;
  import wb_pkg::SRC_ALU;
  import wb_pkg::SRC_MEM;
  import wb_pkg::is_banked;
#(
  parameter int unsigned MEM_FIFO_DEPTH = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_AW         = 4,
  parameter int unsigned NUM_REGS       = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                mark_valid,
  input  logic [REG_AW-1:0]   mark_rd,
  output logic                we_RF,
  output logic [REG_AW-1:0]   rd,
  output logic [DATA_W-1:0]   WD3,
  output logic [NUM_REGS-1:0] pending
);

  localparam int unsigned CNT_W = $clog2(MEM_FIFO_DEPTH) + 1;

  wb_req_t           alu_req;
  wb_req_t           mem_req;
  wb_req_t           fifo_head;
  wb_req_t           sel_req;
  wb_src_e           sel;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W-1:0]  fifo_count;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign mem_req = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (mem_req),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count),
    .head_c  (fifo_head)
  );

  // A full buffer preempts the ALU so loads can never deadlock behind it.
  always_comb begin
    sel     = SRC_NONE;
    sel_req = '0;
    if (fifo_full) begin
      sel     = SRC_MEM;
      sel_req = fifo_head;
    end else if (alu_valid) begin
      sel     = SRC_ALU;
      sel_req = alu_req;
    end else if (!fifo_empty) begin
      sel     = SRC_MEM;
      sel_req = fifo_head;
    end
  end

  assign fifo_pop  = (sel == SRC_MEM);
  assign alu_ready = !fifo_full;
  assign mem_ready = !fifo_full || fifo_pop;
  assign fifo_push = mem_valid && mem_ready;

  // Write port register; rd/WD3 hold their value on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_RF <= 1'b0;
      rd    <= '0;
      WD3   <= '0;
    end else begin
      we_RF <= 1'b0;
      if (sel != SRC_NONE) begin
        we_RF <= is_banked(sel_req.rd);
        rd    <= sel_req.rd;
        WD3   <= sel_req.data;
      end
    end
  end

  // Scoreboard clears once the write is presented to the bank; a new
  // reservation in that same cycle takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (mark_valid && (mark_rd == REG_AW'(i))) begin
          pending[i] <= 1'b1;
        end else if (we_RF && (rd == REG_AW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed self-checking bench for rf_writeback_unit.
module tb_rf_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        mark_valid = 1'b0;
  logic [3:0]  mark_rd = '0;
  logic        we_RF;
  logic [3:0]  rd;
  logic [31:0] WD3;
  logic [14:0] pending;

  int checks = 0;
  int errors = 0;
  logic [31:0] bank [16];

  rf_writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .we_RF      (we_RF),
    .rd         (rd),
    .WD3        (WD3),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Register bank model writes on the falling edge.
  always @(negedge clk) begin
    if (we_RF) bank[rd] <= WD3;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    checks++;
    if ({we_RF, rd, WD3} !== 37'd0) begin
      errors++; $display("FAIL reset_outputs got we=%b rd=%0d wd=%h want 0", we_RF, rd, WD3);
    end
    checks++;
    if (pending !== 15'h0) begin
      errors++; $display("FAIL reset_pending got %h want 0", pending);
    end
    checks++;
    if ({alu_ready, mem_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b want 11", {alu_ready, mem_ready});
    end
    tick; tick;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we_RF !== 1'b0) begin
      errors++; $display("FAIL reset_release_we got %b want 0", we_RF);
    end
  endtask

  task automatic test_alu_only;
    tick;
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++; $display("FAIL alu_ready got %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({we_RF, rd, WD3} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
      errors++; $display("FAIL alu_commit got we=%b rd=%0d wd=%h want 1/3/deadbeef", we_RF, rd, WD3);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({we_RF, rd, WD3} !== {1'b0, 4'd3, 32'hDEADBEEF}) begin
      errors++; $display("FAIL alu_idle_hold got we=%b rd=%0d wd=%h want 0/3/deadbeef", we_RF, rd, WD3);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bank[3] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_bank got %h want deadbeef", bank[3]);
    end
  endtask

  task automatic test_load_latency;
    tick;
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 32'h12345678;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready got %b want 1", mem_ready);
    end
    tick;
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (we_RF !== 1'b0) begin
      errors++; $display("FAIL load_no_bypass got we=%b want 0", we_RF);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({we_RF, rd, WD3} !== {1'b1, 4'd5, 32'h12345678}) begin
      errors++; $display("FAIL load_commit got we=%b rd=%0d wd=%h want 1/5/12345678", we_RF, rd, WD3);
    end
    tick;
    @(negedge clk);
    checks++;
    if (we_RF !== 1'b0) begin
      errors++; $display("FAIL load_after got we=%b want 0", we_RF);
    end
  endtask

  task automatic test_priority_full;
    tick;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'hA1A1A1A1;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_rd = 4'(7 + k); mem_data = 32'h7000 + 32'(7 + k);
      @(negedge clk);
      checks++;
      if ({alu_ready, mem_ready} !== 2'b11) begin
        errors++; $display("FAIL prio_fill_ready[%0d] got %b want 11", k, {alu_ready, mem_ready});
      end
      tick;
    end
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_ready, dut.fifo_count, we_RF, rd} !== {1'b0, 3'd4, 1'b1, 4'd1}) begin
      errors++; $display("FAIL prio_full got ardy=%b cnt=%0d we=%b rd=%0d want 0/4/1/1", alu_ready, dut.fifo_count, we_RF, rd);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({we_RF, rd, WD3, alu_ready} !== {1'b1, 4'd7, 32'h7007, 1'b1}) begin
      errors++; $display("FAIL prio_drain7 got we=%b rd=%0d wd=%h ardy=%b want 1/7/7007/1", we_RF, rd, WD3, alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({we_RF, rd} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL prio_alu_resume got we=%b rd=%0d want 1/1", we_RF, rd);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      @(negedge clk);
      checks++;
      if ({we_RF, rd, WD3} !== {1'b1, 4'(8 + k), 32'h7000 + 32'(8 + k)}) begin
        errors++; $display("FAIL prio_order[%0d] got we=%b rd=%0d wd=%h want rd=%0d", k, we_RF, rd, WD3, 8 + k);
      end
    end
    tick;
    @(negedge clk);
    checks++;
    if (we_RF !== 1'b0) begin
      errors++; $display("FAIL prio_empty got we=%b want 0", we_RF);
    end
  endtask

  task automatic test_full_push_pop;
    tick;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'hB0B0B0B0;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_rd = 4'(11 + k); mem_data = 32'h7000 + 32'(11 + k);
      tick;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 32'h7002;
    @(negedge clk);
    checks++;
    if ({mem_ready, alu_ready, dut.fifo_count} !== {1'b1, 1'b0, 3'd4}) begin
      errors++; $display("FAIL full_pushpop_ready got mrdy=%b ardy=%b cnt=%0d want 1/0/4", mem_ready, alu_ready, dut.fifo_count);
    end
    tick;
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({dut.fifo_count, we_RF, rd} !== {3'd4, 1'b1, 4'd11}) begin
      errors++; $display("FAIL full_pushpop_count got cnt=%0d we=%b rd=%0d want 4/1/11", dut.fifo_count, we_RF, rd);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      @(negedge clk);
      checks++;
      if ({we_RF, rd} !== {1'b1, (k < 3) ? 4'(12 + k) : 4'd2}) begin
        errors++; $display("FAIL full_pushpop_order[%0d] got we=%b rd=%0d", k, we_RF, rd);
      end
    end
    tick;
    @(negedge clk);
    checks++;
    if ({we_RF, dut.fifo_count, bank[2]} !== {1'b0, 3'd0, 32'h7002}) begin
      errors++; $display("FAIL full_pushpop_end got we=%b cnt=%0d bank2=%h want 0/0/7002", we_RF, dut.fifo_count, bank[2]);
    end
  endtask

  task automatic test_scoreboard;
    tick;
    mark_valid = 1'b1; mark_rd = 4'd6;
    tick;
    mark_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending !== 15'h0040) begin
      errors++; $display("FAIL sb_set got %h want 0040", pending);
    end
    tick;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 32'h66;
    tick;
    alu_valid = 1'b0;
    tick;
    @(negedge clk);
    checks++;
    if (pending !== 15'h0000) begin
      errors++; $display("FAIL sb_clear got %h want 0000", pending);
    end
    // Reserve again while the commit to r6 is on the write port.
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 32'h67;
    tick;
    alu_valid = 1'b0;
    mark_valid = 1'b1; mark_rd = 4'd6;
    @(negedge clk);
    checks++;
    if ({we_RF, rd} !== {1'b1, 4'd6}) begin
      errors++; $display("FAIL sb_same_commit got we=%b rd=%0d want 1/6", we_RF, rd);
    end
    tick;
    mark_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending !== 15'h0040) begin
      errors++; $display("FAIL sb_set_wins got %h want 0040", pending);
    end
    tick;
    mark_valid = 1'b1; mark_rd = 4'd15;
    tick;
    mark_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending !== 15'h0040) begin
      errors++; $display("FAIL sb_mark_pc got %h want 0040", pending);
    end
  endtask

  task automatic test_pc;
    tick;
    alu_valid = 1'b1; alu_rd = 4'd15; alu_data = 32'hFFFF0000;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++; $display("FAIL pc_ready got %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({we_RF, pending} !== {1'b0, 15'h0040}) begin
      errors++; $display("FAIL pc_commit got we=%b pending=%h want 0/0040", we_RF, pending);
    end
  endtask

  task automatic test_reset_midop;
    tick;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'hC1C1C1C1;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_rd = 4'(7 + k); mem_data = 32'h7000 + 32'(7 + k);
      tick;
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({we_RF, rd, WD3, pending, dut.fifo_count} !== 55'd0) begin
      errors++; $display("FAIL rst_mid got we=%b rd=%0d wd=%h pend=%h cnt=%0d want all 0", we_RF, rd, WD3, pending, dut.fifo_count);
    end
    tick; tick;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (we_RF !== 1'b0) begin
        errors++; $display("FAIL rst_no_write[%0d] got we=%b want 0", k, we_RF);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_alu_only;
    test_load_latency;
    test_priority_full;
    test_full_push_pop;
    test_scoreboard;
    test_pc;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
